// File: rtl/ana_cfg_pkg.sv
// Shared constants and types for the analog configuration loader.
// Top-levels use the CH_* indices to pick channel fields out of cfg_out.
package ana_cfg_pkg;

  localparam int NUM_CH_DEF      = 4;
  localparam int CH_W_DEF        = 8;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int CFG_BITS        = NUM_CH_DEF * CH_W_DEF;

  // Channel assignment within cfg_out (channel k = bits [k*CH_W +: CH_W]).
  localparam int CH_BIAS = 0;
  localparam int CH_EN   = 1;
  localparam int CH_TRIM = 2;
  localparam int CH_AUX  = 3;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SHIFTING = 2'd1,
    ST_OVERFLOW = 2'd2
  } cfg_state_e;

  typedef struct packed {
    cfg_state_e state;
    logic [2:0] lvl;   // {load, dat, clk} synchronised levels
    logic [2:0] rise;  // {load, dat, clk} rise pulses before ena gating
  } cfg_dbg_t;

  // Counter must hold 0..n+1 so overflow stays distinguishable from a full chain.
  function automatic int cnt_width(input int n);
    return $clog2(n + 2);
  endfunction

endpackage

// File: rtl/ana_cfg_loader_if.sv
// Serial pin and configuration bundle between the tile pins and the loader.
// cfg_valid is a one-cycle, unacknowledged pulse: consumers must sample cfg_out in that cycle or simply follow cfg_out.
interface ana_cfg_loader_if #(
  parameter int CFG_BITS = ana_cfg_pkg::CFG_BITS
);
  import ana_cfg_pkg::*;

  logic                ena;
  logic                ser_clk;
  logic                ser_dat;
  logic                ser_load;
  logic                ser_dout;
  logic [CFG_BITS-1:0] cfg_out;
  logic                cfg_valid;
  logic                cfg_err;
  cfg_dbg_t            dbg;

  modport master (
    output ena, ser_clk, ser_dat, ser_load,
    input  ser_dout, cfg_out, cfg_valid, cfg_err, dbg
  );

  modport slave (
    input  ena, ser_clk, ser_dat, ser_load,
    output ser_dout, cfg_out, cfg_valid, cfg_err, dbg
  );

endinterface

// File: rtl/ana_sync_edge.sv
// Multi-flop synchroniser for one asynchronous pin plus a history flop for rise detection.
module ana_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~hist_q;

endmodule

// File: rtl/ana_cfg_loader.sv
// Oversampled serial shift chain with atomic commit into the shadow registers feeding the analog macros.
module ana_cfg_loader
  import ana_cfg_pkg::*;
#(
  parameter int NUM_CH      = NUM_CH_DEF,
  parameter int CH_W        = CH_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input logic               clk,
  input logic               rst_n,
  ana_cfg_loader_if.slave   bus
);

  localparam int N  = NUM_CH * CH_W;
  localparam int CW = cnt_width(N);

  logic          lvl_clk, lvl_dat, lvl_load;
  logic          rise_clk, rise_dat, rise_load;
  logic          do_shift, do_load;
  logic [N-1:0]  chain_q, chain_nxt;
  logic [CW-1:0] cnt_q, cnt_nxt;
  logic [N-1:0]  cfg_q, cfg_nxt;
  logic          valid_q, valid_nxt;
  logic          err_q, err_nxt;
  cfg_state_e    state;
  cfg_dbg_t      dbg_s;

  ana_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clk (
    .clk(clk), .rst_n(rst_n), .din(bus.ser_clk), .level(lvl_clk), .rise(rise_clk)
  );
  ana_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_dat (
    .clk(clk), .rst_n(rst_n), .din(bus.ser_dat), .level(lvl_dat), .rise(rise_dat)
  );
  ana_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_load (
    .clk(clk), .rst_n(rst_n), .din(bus.ser_load), .level(lvl_load), .rise(rise_load)
  );

  // Gating only the pulses keeps history tracking, so raising ena with a pin high is not an edge.
  assign do_shift = rise_clk  & bus.ena;
  assign do_load  = rise_load & bus.ena;

  // Shift is resolved first so a coincident load commits the post-shift chain and count.
  always_comb begin
    chain_nxt = chain_q;
    cnt_nxt   = cnt_q;
    cfg_nxt   = cfg_q;
    valid_nxt = 1'b0;
    err_nxt   = err_q;
    if (do_shift) begin
      chain_nxt = {chain_q[N-2:0], lvl_dat};
      if (cnt_q != CW'(N + 1)) cnt_nxt = cnt_q + CW'(1);
    end
    if (do_load) begin
      if (cnt_nxt == CW'(N)) begin
        cfg_nxt   = chain_nxt;
        valid_nxt = 1'b1;
      end else begin
        err_nxt = 1'b1;
      end
      cnt_nxt = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chain_q <= '0;
      cnt_q   <= '0;
      cfg_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      chain_q <= chain_nxt;
      cnt_q   <= cnt_nxt;
      cfg_q   <= cfg_nxt;
      valid_q <= valid_nxt;
      err_q   <= err_nxt;
    end
  end

  always_comb begin
    state = ST_SHIFTING;
    if (cnt_q == '0)                state = ST_IDLE;
    else if (cnt_q == CW'(N + 1))   state = ST_OVERFLOW;
    dbg_s       = '0;
    dbg_s.state = state;
    dbg_s.lvl   = {lvl_load, lvl_dat, lvl_clk};
    dbg_s.rise  = {rise_load, rise_dat, rise_clk};
  end

  assign bus.ser_dout  = chain_q[N-1];
  assign bus.cfg_out   = cfg_q;
  assign bus.cfg_valid = valid_q;
  assign bus.cfg_err   = err_q;
  assign bus.dbg       = dbg_s;

endmodule

// File: tb/tb_ana_cfg_loader.sv
// Directed bench for ana_cfg_loader: serial driver tasks, commit scoreboard, immediate-assertion checks.
module tb_ana_cfg_loader;
  import ana_cfg_pkg::*;

  localparam int N = 32;

  logic clk;
  logic rst_n;
  int   total_cnt;
  int   pass_cnt;
  int   fail_cnt;
  logic [N-1:0] exp_q[$];

  ana_cfg_loader_if #(.CFG_BITS(N)) bus ();

  ana_cfg_loader #(.NUM_CH(4), .CH_W(8), .SYNC_STAGES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every cfg_valid pulse must match the oldest pending commit.
  always @(negedge clk) begin
    if (rst_n && bus.cfg_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_valid", 64'(bus.cfg_out), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        chk("sb_cfg_out", 64'(bus.cfg_out), 64'(exp_q.pop_front()));
      end
    end
  end

  // Driver tasks
  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ser_bit(input logic b);
    @(negedge clk);
    bus.ser_dat = b;
    wait_n(3);
    bus.ser_clk = 1'b1;
    wait_n(4);
    bus.ser_clk = 1'b0;
    wait_n(3);
  endtask

  task automatic shift_bits(input logic [63:0] val, input int n);
    for (int i = n - 1; i >= 0; i--) ser_bit(val[i]);
  endtask

  // Load rise driven before edge n: valid must be low after n+1, high after n+2 (if ok), low after n+3.
  task automatic load_window(input string tag, input logic exp_ok);
    wait_n(1);
    wait_n(1); chk({tag, "_valid_early"}, 64'(bus.cfg_valid), 64'd0);
    wait_n(1); chk({tag, "_valid_pulse"}, 64'(bus.cfg_valid), 64'(exp_ok));
    wait_n(1); chk({tag, "_valid_width"}, 64'(bus.cfg_valid), 64'd0);
    wait_n(2);
    bus.ser_load = 1'b0;
    bus.ser_clk  = 1'b0;
    wait_n(4);
  endtask

  task automatic pulse_load(input string tag, input logic exp_ok);
    @(negedge clk);
    bus.ser_load = 1'b1;
    load_window(tag, exp_ok);
  endtask

  task automatic shift_and_load(input string tag, input logic b);
    @(negedge clk);
    bus.ser_dat = b;
    wait_n(3);
    bus.ser_clk  = 1'b1;
    bus.ser_load = 1'b1;
    load_window(tag, 1'b1);
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst_n = 1'b0;
    wait_n(cycles);
    rst_n = 1'b1;
    wait_n(2);
  endtask

  logic [63:0] ovf_val;

  initial begin
    total_cnt = 0; pass_cnt = 0; fail_cnt = 0;
    rst_n = 1'b0;
    bus.ena = 1'b1; bus.ser_clk = 1'b0; bus.ser_dat = 1'b0; bus.ser_load = 1'b0;

    // 1. Reset with random pin activity
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.ser_clk  = 1'($urandom_range(0, 1));
      bus.ser_dat  = 1'($urandom_range(0, 1));
      bus.ser_load = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    chk("rst_cfg_out",   64'(bus.cfg_out),   64'd0);
    chk("rst_cfg_valid", 64'(bus.cfg_valid), 64'd0);
    chk("rst_cfg_err",   64'(bus.cfg_err),   64'd0);
    chk("rst_ser_dout",  64'(bus.ser_dout),  64'd0);
    chk("rst_state",     64'(bus.dbg.state), 64'(ST_IDLE));
    bus.ser_clk = 1'b0; bus.ser_dat = 1'b0; bus.ser_load = 1'b0;
    wait_n(3);
    rst_n = 1'b1;
    wait_n(4);
    chk("post_rst_state", 64'(bus.dbg.state), 64'(ST_IDLE));

    // 2. Good load
    shift_bits(64'hA5C3_0F81, 32);
    chk("good_ser_dout", 64'(bus.ser_dout),  64'd1);
    chk("good_state",    64'(bus.dbg.state), 64'(ST_SHIFTING));
    exp_q.push_back(32'hA5C3_0F81);
    pulse_load("good", 1'b1);
    chk("good_cfg_out",  64'(bus.cfg_out),   64'hA5C3_0F81);
    chk("good_cfg_err",  64'(bus.cfg_err),   64'd0);
    chk("good_idle",     64'(bus.dbg.state), 64'(ST_IDLE));
    chk("good_readback", 64'(bus.ser_dout),  64'd1);

    // 3. Short load then good load
    shift_bits(64'h1234_5678, 31);
    pulse_load("short", 1'b0);
    chk("short_cfg_out", 64'(bus.cfg_out), 64'hA5C3_0F81);
    chk("short_cfg_err", 64'(bus.cfg_err), 64'd1);
    shift_bits(64'h5A5A_1234, 32);
    exp_q.push_back(32'h5A5A_1234);
    pulse_load("after_short", 1'b1);
    chk("after_short_cfg_out", 64'(bus.cfg_out), 64'h5A5A_1234);
    chk("after_short_err",     64'(bus.cfg_err), 64'd1);

    // 4. Overflow, from a clean error flag
    do_reset(2);
    chk("rst2_cfg_out", 64'(bus.cfg_out), 64'd0);
    chk("rst2_cfg_err", 64'(bus.cfg_err), 64'd0);
    shift_bits(64'h0F0F_F0F0, 32);
    exp_q.push_back(32'h0F0F_F0F0);
    pulse_load("pre_ovf", 1'b1);
    ovf_val = 64'h3C_8012_3456;
    shift_bits(ovf_val, 40);
    chk("ovf_state",    64'(bus.dbg.state), 64'(ST_OVERFLOW));
    chk("ovf_ser_dout", 64'(bus.ser_dout),  64'(ovf_val[39 - 8]));
    pulse_load("ovf", 1'b0);
    chk("ovf_cfg_err",  64'(bus.cfg_err), 64'd1);
    chk("ovf_cfg_out",  64'(bus.cfg_out), 64'h0F0F_F0F0);

    // 5. ena gating
    do_reset(2);
    shift_bits(64'h1111_2222, 32);
    exp_q.push_back(32'h1111_2222);
    pulse_load("pre_ena", 1'b1);
    bus.ena = 1'b0;
    shift_bits(64'hDEAD_BEEF, 32);
    pulse_load("ena_off", 1'b0);
    chk("ena_off_cfg_out", 64'(bus.cfg_out),   64'h1111_2222);
    chk("ena_off_cfg_err", 64'(bus.cfg_err),   64'd0);
    chk("ena_off_state",   64'(bus.dbg.state), 64'(ST_IDLE));
    @(negedge clk);
    bus.ser_clk = 1'b1;
    wait_n(6);
    bus.ena = 1'b1;
    wait_n(6);
    bus.ser_clk = 1'b0;
    wait_n(4);
    chk("ena_rise_no_shift", 64'(bus.dbg.state), 64'(ST_IDLE));
    shift_bits(64'h3C3C_A5A5, 32);
    exp_q.push_back(32'h3C3C_A5A5);
    pulse_load("ena_on", 1'b1);
    chk("ena_on_cfg_out", 64'(bus.cfg_out), 64'h3C3C_A5A5);
    chk("ena_on_cfg_err", 64'(bus.cfg_err), 64'd0);

    // 6. Reset mid-transfer, then coincident clock/load on the last bit
    shift_bits(64'hFFFF, 16);
    chk("mid_state", 64'(bus.dbg.state), 64'(ST_SHIFTING));
    do_reset(2);
    chk("mid_rst_cfg_out", 64'(bus.cfg_out),   64'd0);
    chk("mid_rst_state",   64'(bus.dbg.state), 64'(ST_IDLE));
    shift_bits(64'h6000_E806, 31);
    exp_q.push_back(32'hC001_D00D);
    shift_and_load("simul", 1'b1);
    chk("simul_cfg_out", 64'(bus.cfg_out),   64'hC001_D00D);
    chk("simul_cfg_err", 64'(bus.cfg_err),   64'd0);
    chk("simul_state",   64'(bus.dbg.state), 64'(ST_IDLE));

    wait_n(4);
    chk("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/ana_cfg_loader.md
Name: ana_cfg_loader

Overview:
Serial configuration loader that sets analog trim/enable bits on the TT analog tile from dedicated digital inputs. It oversamples a slow serial interface (clock, data, load) with the system clock and shifts bits into a NUM_CH x CH_W chain. On a load strobe it transfers the chain atomically into shadow registers that drive the analog macros. It sits between ui_in/uo_out and the analog sub-blocks in tt_um_* top-levels, replacing the hard-wired tie-offs used so far.

Parameters:
NUM_CH, 4, number of analog channels configured
CH_W, 8, configuration bits per channel
SYNC_STAGES, 2, synchroniser depth for asynchronous serial inputs (>=2)

Ports:
clk  in  1  system clock; the block's only clock
rst_n  in  1  synchronous active-low reset
ena  in  1  tile enable; when 0, serial edges are ignored
ser_clk  in  1  asynchronous serial clock (pin)
ser_dat  in  1  asynchronous serial data, MSB first (pin)
ser_load  in  1  asynchronous load strobe (pin); a rising edge commits the chain
ser_dout  out  1  MSB of the shift chain, for daisy-chain and readback
cfg_out  out  NUM_CH*CH_W  committed configuration; channel k = bits [k*CH_W +: CH_W]
cfg_valid  out  1  one-cycle pulse after a successful commit
cfg_err  out  1  sticky: a load occurred with a bit count not equal to NUM_CH*CH_W

Behaviour:
- Reset (rst_n=0 at a clk edge): synchronisers, edge-history flops, shift chain, bit counter, cfg_out, cfg_valid and cfg_err all go to 0. ser_dout=0. Reset applies regardless of ena.
- Sync: ser_clk, ser_dat and ser_load each pass through SYNC_STAGES flops plus one history flop. rise_x = sync_x & ~hist_x.
- Latency: with SYNC_STAGES=2, a pin edge that is stable before clk edge n is acted upon at edge n+2, i.e. the register update is visible after edge n+2.
- Shift: on rise_clk with ena=1, chain <= {chain[N-2:0], sync_dat}, where N=NUM_CH*CH_W. The data value used is sync_dat in the same cycle as the edge detect; ser_dat must be stable for at least SYNC_STAGES+1 clk cycles around the ser_clk rise. The bit counter increments and saturates at N+1 (a width of clog2(N+2) bits is enough). Saturation does not wrap.
- ser_dout = chain[N-1] (registered). After exactly N shifts, the first bit shifted in is at ser_dout.
- Commit: on rise_load with ena=1:
  - If count==N: cfg_out <= chain; cfg_valid=1 for exactly one cycle.
  - Otherwise: cfg_out is unchanged and cfg_err <= 1.
  - In both cases the counter clears to 0. The chain is NOT cleared, which allows readback.
- Simultaneous rise_clk and rise_load in the same cycle: the shift happens first. The commit then uses the post-shift chain and a count of old+1 (saturated). The chain and the counter update in the same cycle.
- cfg_err clears only on reset. A successful commit does not clear it.
- ena=0: edge detects are masked. Synchronisers and history still track, so no spurious edge occurs when ena rises with a pin held high. cfg_out holds its value.
- Reset mid-transfer discards partial bits. cfg_out returns to 0, i.e. the analog blocks return to their safe default.
- States: IDLE (count=0), SHIFTING (0<count<=N), OVERFLOW (count=N+1). The state is fully encoded by the counter; no separate FSM register is needed.

Decomposition:
- Package ana_cfg_pkg: constants for default NUM_CH/CH_W, CFG_BITS=NUM_CH*CH_W, count width function, and per-channel field-index localparams (e.g. CH_BIAS, CH_EN) used by the top-levels.
- Sub-module ana_sync_edge: parametrised SYNC_STAGES synchroniser plus history flop, outputting sync level and rise pulse. Instantiated three times.

Test Plan:
1. Reset: drive random pins, hold rst_n=0 for 3 clk -> cfg_out=0, cfg_valid=0, cfg_err=0, ser_dout=0.
2. Good load (NUM_CH=4, CH_W=8): shift 32 bits 0xA5C3_0F81 MSB first, then pulse load -> cfg_out=0xA5C30F81, cfg_valid high for exactly 1 cycle, 2 cycles after sync of load, cfg_err=0.
3. Short load: shift 31 bits, then load -> cfg_out unchanged, cfg_err=1, cfg_valid never asserts. A subsequent good 32-bit load -> cfg_out updates, cfg_err stays 1.
4. Overflow: shift 40 bits, then load -> cfg_err=1, cfg_out unchanged. Verify ser_dout equals bit 8 of the sequence after the 40th shift.
5. ena gating: with ena=0, shift 32 bits and load -> no change, no error. Raise ena with ser_clk held high -> no shift occurs.
6. Mid-operation: reset after 16 bits, then a 32-bit load -> committed value contains only post-reset bits. Also drive a simultaneous ser_clk/ser_load rise on bit 32 -> commit succeeds with that bit included.
